// File: rtl/divider_iter_if.sv
// Handshake and operand/result bundle for divider_iter.
// signed_mode exists only when DIVIDER_SIGNED_EN is defined.
interface divider_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef DIVIDER_SIGNED_EN
  logic             signed_mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

`ifdef DIVIDER_SIGNED_EN
  modport master (
    output start, a, b, signed_mode,
    input  busy, done, q, r, div_by_zero
  );
  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, q, r, div_by_zero
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, q, r, div_by_zero
  );
  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_by_zero
  );
`endif
endinterface

// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN to compile in two's-complement mode (signed_mode port).
module divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  divider_iter_if.slave dif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             dz;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             dz_r;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // quo holds the not-yet-consumed dividend bits on top, quotient bits fill in from below
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs};
    rem_nx = rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
  end

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic a_neg;
  logic b_neg;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? (-sv) : sv;
  endfunction

  function automatic logic is_neg(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return en && (sv < 0);
  endfunction

  // Remainder re-signed from |a| also reproduces a itself when dividing by zero
  always_comb begin
    a_neg = is_neg(dif.a, dif.signed_mode);
    b_neg = is_neg(dif.b, dif.signed_mode);
    a_mag = cond_neg(dif.a, a_neg);
    b_mag = cond_neg(dif.b, b_neg);
    q_fin = dz ? '1 : cond_neg(quo_nx, neg_q);
    r_fin = cond_neg(rem_nx, neg_r);
  end
`else
  always_comb begin
    a_mag = dif.a;
    b_mag = dif.b;
    q_fin = dz ? '1 : quo_nx;
    r_fin = rem_nx;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      dz     <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      dz_r   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (dif.start) begin
            state  <= S_RUN;
            busy_r <= 1'b1;
            cnt    <= '0;
            rem    <= '0;
            quo    <= a_mag;
            dvs    <= b_mag;
            dz     <= (dif.b == '0);
`ifdef DIVIDER_SIGNED_EN
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          // Last iteration: results and sign fix-up land on this same edge
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            q_r    <= q_fin;
            r_r    <= r_fin;
            dz_r   <= dz;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dif.busy        = busy_r;
  assign dif.done        = done_r;
  assign dif.q           = q_r;
  assign dif.r           = r_r;
  assign dif.div_by_zero = dz_r;

endmodule

// File: tb/tb_divider_iter.sv
// Directed bench for divider_iter: 32-bit vector table, 8-bit sweep, handshake and reset corners.
module tb_divider_iter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  divider_iter_if #(.WIDTH(32)) d32 ();
  divider_iter_if #(.WIDTH(8))  d8 ();

  divider_iter #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .dif(d32));
  divider_iter #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .dif(d8));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic get_out(input bit s8, output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic busy, output logic done);
    if (s8) begin
      q = {24'b0, d8.q}; r = {24'b0, d8.r}; dz = d8.div_by_zero; busy = d8.busy; done = d8.done;
    end else begin
      q = d32.q; r = d32.r; dz = d32.div_by_zero; busy = d32.busy; done = d32.done;
    end
  endtask

  // Drives start on the negedge, returns #1 after the accepting edge with start dropped
  task automatic launch(input bit s8, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (s8) begin
      d8.a = a[7:0]; d8.b = b[7:0]; d8.start = 1'b1;
    end else begin
      d32.a = a; d32.b = b; d32.start = 1'b1;
    end
    @(posedge clk);
    #1;
    d8.start = 1'b0;
    d32.start = 1'b0;
  endtask

  task automatic wait_done(input bit s8, input int init, output int edges);
    logic [31:0] q, r;
    logic dz, busy, done;
    edges = init;
    get_out(s8, q, r, dz, busy, done);
    while (!done && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      get_out(s8, q, r, dz, busy, done);
    end
  endtask

  task automatic run(input bit s8, input string tag, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] q, output logic [31:0] r, output logic dz, output int lat);
    logic busy, done;
    launch(s8, a, b);
    get_out(s8, q, r, dz, busy, done);
    check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
    wait_done(s8, 1, lat);
    get_out(s8, q, r, dz, busy, done);
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] q, r;
    logic dz, busy, done;
    int lat;
    int bl[11];

    tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1};
    tbl[2]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    tbl[3]  = '{32'd5,          32'd5,          32'd1,          32'd0,          1'b0};
    tbl[4]  = '{32'd4,          32'd5,          32'd0,          32'd4,          1'b0};
    tbl[5]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tbl[6]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    tbl[7]  = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0};
    tbl[8]  = '{32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0};
    tbl[9]  = '{32'hFFFFFFFF,   32'h00010000,   32'h0000FFFF,   32'h0000FFFF,   1'b0};
    tbl[10] = '{32'd12345,      32'h80000000,   32'd0,          32'd12345,      1'b0};
    bl = '{1, 2, 3, 7, 10, 16, 37, 100, 128, 200, 255};

    d32.start = 1'b0; d32.a = '0; d32.b = '0;
    d8.start = 1'b0;  d8.a = '0;  d8.b = '0;
`ifdef DIVIDER_SIGNED_EN
    d32.signed_mode = 1'b0;
    d8.signed_mode = 1'b0;
`endif
    reset = 1'b0;
    #1 reset = 1'b1;
    #11;
    get_out(0, q, r, dz, busy, done);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_dz", {31'b0, dz}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run(0, $sformatf("v%0d", i), tbl[i].a, tbl[i].b, q, r, dz, lat);
      check($sformatf("v%0d_q", i), q, tbl[i].q);
      check($sformatf("v%0d_r", i), r, tbl[i].r);
      check($sformatf("v%0d_dz", i), {31'b0, dz}, {31'b0, tbl[i].dz});
      check($sformatf("v%0d_lat", i), lat, 33);
      @(posedge clk);
      #1;
      get_out(0, q, r, dz, busy, done);
      check($sformatf("v%0d_done_drop", i), {31'b0, done}, 32'd0);
      check($sformatf("v%0d_q_hold", i), q, tbl[i].q);
    end

    // start during RUN must be ignored, then back-to-back start right after done
    launch(0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    d32.a = 32'd999; d32.b = 32'd1; d32.start = 1'b1;
    @(posedge clk);
    #1;
    d32.start = 1'b0;
    wait_done(0, 6, lat);
    get_out(0, q, r, dz, busy, done);
    check("ign_lat", lat, 33);
    check("ign_q", q, 32'd14);
    check("ign_r", r, 32'd2);
    d32.a = 32'd50; d32.b = 32'd3; d32.start = 1'b1;
    @(posedge clk);
    #1;
    d32.start = 1'b0;
    get_out(0, q, r, dz, busy, done);
    check("b2b_done_drop", {31'b0, done}, 32'd0);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done(0, 1, lat);
    get_out(0, q, r, dz, busy, done);
    check("b2b_lat", lat, 33);
    check("b2b_q", q, 32'd16);
    check("b2b_r", r, 32'd2);

    // asynchronous reset in the middle of an operation
    launch(0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    get_out(0, q, r, dz, busy, done);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_q", q, 32'd0);
    check("mid_rst_r", r, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(0, "post_rst", 32'd100, 32'd7, q, r, dz, lat);
    check("post_rst_q", q, 32'd14);
    check("post_rst_r", r, 32'd2);
    check("post_rst_lat", lat, 33);

    // 8-bit sweep against the language's own / and %
    for (int ai = 0; ai < 256; ai += 5) begin
      for (int bi = 0; bi < 11; bi++) begin
        run(1, "w8", ai, bl[bi], q, r, dz, lat);
        check($sformatf("w8_%0d_%0d_q", ai, bl[bi]), q, ai / bl[bi]);
        check($sformatf("w8_%0d_%0d_r", ai, bl[bi]), r, ai % bl[bi]);
        check($sformatf("w8_%0d_%0d_lat", ai, bl[bi]), lat, 9);
      end
    end
    run(1, "w8z", 32'd200, 32'd0, q, r, dz, lat);
    check("w8z_q", q, 32'hFF);
    check("w8z_r", r, 32'd200);
    check("w8z_dz", {31'b0, dz}, 32'd1);
    check("w8z_lat", lat, 9);

`ifdef DIVIDER_SIGNED_EN
    @(negedge clk);
    d8.signed_mode = 1'b1;
    run(1, "s1", 32'hF9, 32'h02, q, r, dz, lat);
    check("s_m7_2_q", q, 32'hFD);
    check("s_m7_2_r", r, 32'hFF);
    check("s_m7_2_lat", lat, 9);
    run(1, "s2", 32'h07, 32'hFE, q, r, dz, lat);
    check("s_7_m2_q", q, 32'hFD);
    check("s_7_m2_r", r, 32'h01);
    run(1, "s3", 32'h80, 32'hFF, q, r, dz, lat);
    check("s_ovf_q", q, 32'h80);
    check("s_ovf_r", r, 32'h00);
    run(1, "s4", 32'hF9, 32'h00, q, r, dz, lat);
    check("s_dz_q", q, 32'hFF);
    check("s_dz_r", r, 32'hF9);
    check("s_dz_dz", {31'b0, dz}, 32'd1);
    @(negedge clk);
    d8.signed_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
